// File: rtl/sender_msg_pkg.sv
// Shared constants, state encoding and sizing helper for the sender tree message reader.
package sender_msg_pkg;
    localparam int LANES      = 16;
    localparam int LANE_BITS  = $clog2(LANES);
    localparam int MSG_W      = 64;
    localparam int MSG_PAIR_W = 2 * MSG_W;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} rd_state_t;

    function automatic int num_msg(input int d);
        return LANES * (1 << (d + 3));
    endfunction
endpackage

// File: rtl/sender_msg_reader_if.sv
// Control, tree-read and output-stream signals of the message reader.
interface sender_msg_reader_if;
    import sender_msg_pkg::*;

    logic                  start;
    logic [31:0]           base_index;
    logic [31:0]           count;
    logic [31:0]           msg_index;
    logic [MSG_PAIR_W-1:0] msg_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [MSG_PAIR_W-1:0] m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_index, count, msg_data, m_ready,
        output msg_index, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        output start, base_index, count, msg_data, m_ready,
        input  msg_index, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/msg_skid_fifo.sv
// Small output skid FIFO; head is read combinationally, push-while-full is legal only with a pop.
module msg_skid_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/sender_msg_reader.sv
// Walks msg_index over a requested range, captures the tree's {m1,m0} once its BRAM word
// matches the presented index, and streams the messages out through a skid FIFO.
module sender_msg_reader
    import sender_msg_pkg::*;
#(
    parameter int D          = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    sender_msg_reader_if.master bus
);
    localparam int          NUM_MSG  = num_msg(D);
    localparam logic [31:0] IDX_MASK = 32'(NUM_MSG - 1);

    rd_state_t             state, state_nxt;
    logic [31:0]           idx;
    logic [31:0]           remaining;
    logic [31:0]           word_tag;
    logic                  word_tag_valid;
    logic                  zero_done;
    logic                  accept;
    logic                  capture;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  head_last;
    logic [MSG_PAIR_W-1:0] head_data;

    assign accept = (state == IDLE) && bus.start;
    assign pop    = !empty && bus.m_ready;
    // The tree's word register lags the address by a cycle; only capture once it has caught up.
    assign capture = (state == FETCH) && word_tag_valid
                     && (word_tag == (idx >> LANE_BITS)) && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && (bus.count != 32'd0)) state_nxt = FETCH;
            FETCH:   if (capture && (remaining == 32'd1))   state_nxt = DRAIN;
            DRAIN:   if (pop && head_last)                  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            remaining      <= '0;
            word_tag       <= '0;
            word_tag_valid <= 1'b0;
            zero_done      <= 1'b0;
        end else begin
            word_tag       <= idx >> LANE_BITS;
            word_tag_valid <= (state != IDLE);
            zero_done      <= accept && (bus.count == 32'd0);
            if (accept && (bus.count != 32'd0)) begin
                idx       <= bus.base_index & IDX_MASK;
                remaining <= bus.count;
            end else if (capture) begin
                idx       <= (idx + 32'd1) & IDX_MASK;
                remaining <= remaining - 32'd1;
            end
        end
    end

    msg_skid_fifo #(
        .WIDTH (MSG_PAIR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data ({remaining == 32'd1, bus.msg_data}),
        .pop       (pop),
        .head_data ({head_last, head_data}),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        bus.msg_index = idx;
        bus.busy      = (state != IDLE);
        bus.m_valid   = !empty;
        bus.m_data    = empty ? '0 : head_data;
        bus.m_last    = !empty && head_last;
        bus.done      = !rst && (zero_done || ((state == DRAIN) && pop && head_last));
    end
endmodule

// File: tb/tb_sender_msg_reader.sv
// Directed bench: models the tree as a 1-cycle word register plus lane mux returning {i+0x8000, i}.
module tb_sender_msg_reader;
    import sender_msg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sender_msg_reader_if bus();

    sender_msg_reader #(.D(3), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] word_reg = '0;
    logic [63:0] lane_idx;
    always @(posedge clk) word_reg <= bus.msg_index >> 4;
    assign lane_idx     = {32'd0, word_reg * 32'd16 + {28'd0, bus.msg_index[3:0]}};
    assign bus.msg_data = {lane_idx + 64'h8000, lane_idx};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake log and bookkeeping, sampled on the falling edge.
    logic [127:0] hs_dat[$];
    logic         hs_last[$];
    logic         hs_done[$];
    int           hs_cyc[$];
    int cyc = 0, done_cnt = 0, d0 = 0;
    int pushes = 0, pops = 0, frz_hits = 0, frz_err = 0, stab_err = 0;
    logic         prev_busy = 0, prev_v = 0, prev_r = 0, frz_pend = 0;
    logic [31:0]  prev_idx = '0, frz_idx = '0;
    logic [127:0] prev_d = '0;
    logic         rdy_toggle = 0;
    logic [3:0]   rdy_pat = 4'b1001;
    int           rdy_ph = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_busy && bus.msg_index != prev_idx) pushes++;
            if (frz_pend) begin
                frz_hits++;
                if (bus.msg_index != frz_idx) frz_err++;
            end
            frz_pend = (pushes - pops == 2) && !bus.m_ready && bus.busy;
            frz_idx  = bus.msg_index;
            if (prev_v && !prev_r && (!bus.m_valid || bus.m_data != prev_d)) stab_err++;
            if (bus.done) done_cnt++;
            if (bus.m_valid && bus.m_ready) begin
                hs_dat.push_back(bus.m_data);
                hs_last.push_back(bus.m_last);
                hs_done.push_back(bus.done);
                hs_cyc.push_back(cyc);
                pops++;
            end
        end
        prev_busy = bus.busy;
        prev_idx  = bus.msg_index;
        prev_v    = bus.m_valid;
        prev_r    = bus.m_ready;
        prev_d    = bus.m_data;
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) begin
                bus.m_ready = rdy_pat[rdy_ph];
                rdy_ph = (rdy_ph + 1) % 4;
            end else begin
                bus.m_ready = 1'b1;
            end
        end
    end

    task automatic clear_log();
        hs_dat.delete(); hs_last.delete(); hs_done.delete(); hs_cyc.delete();
        pushes = 0; pops = 0; d0 = done_cnt;
    endtask

    task automatic start_rng(input logic [31:0] b, input logic [31:0] c);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_index = b; bus.count = c;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt != d0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_range(input string tag, input int b, input int c, input logic gaps);
        logic [63:0] e;
        int gap_err = 0;
        chk({tag, "_num"}, hs_dat.size(), c);
        for (int k = 0; k < c && k < hs_dat.size(); k++) begin
            e = 64'((b + k) & 1023);
            chk($sformatf("%s_dat%0d", tag, k), hs_dat[k], {e + 64'h8000, e});
            chk($sformatf("%s_last%0d", tag, k), {hs_last[k], hs_done[k]}, (k == c - 1) ? 2'b11 : 2'b00);
            if (gaps && k > 0 && (hs_cyc[k] - hs_cyc[k-1]) != ((e[3:0] == 4'd0) ? 2 : 1)) gap_err++;
        end
        if (gaps) chk({tag, "_bubbles"}, gap_err, 0);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.base_index = '0; bus.count = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outs", {bus.m_valid, bus.m_last, bus.busy, bus.done}, 4'b0000);
        chk("rst_idx", bus.msg_index, 0);
        chk("rst_data", bus.m_data, 0);

        clear_log(); start_rng(0, 20); wait_done("t1");
        check_range("t1", 0, 20, 1'b1);

        clear_log(); start_rng(1022, 4); wait_done("t2");
        check_range("t2", 1022, 4, 1'b1);

        rdy_toggle = 1'b1;
        clear_log(); start_rng(5, 8); wait_done("t3");
        check_range("t3", 5, 8, 1'b0);
        chk("t3_stable", stab_err, 0);
        chk("t3_frz_seen", frz_hits > 0, 1);
        chk("t3_frz_held", frz_err, 0);
        rdy_toggle = 1'b0;
        @(posedge clk); #1;

        clear_log(); start_rng(0, 0);
        @(negedge clk);
        chk("t4_done", {bus.done, bus.busy, bus.m_valid}, 3'b100);
        @(negedge clk);
        chk("t4_after", {bus.done, bus.busy, bus.m_valid}, 3'b000);
        chk("t4_cnt", done_cnt - d0, 1);

        clear_log(); start_rng(30, 6); start_rng(100, 50); wait_done("t5");
        check_range("t5", 30, 6, 1'b1);

        clear_log(); start_rng(40, 10);
        for (int n = 0; n < 100 && hs_dat.size() < 3; n++) begin
            @(negedge clk); #1;
        end
        chk("t6_pre", hs_dat.size() >= 3, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_outs", {bus.m_valid, bus.busy, bus.done}, 3'b000);
        chk("t6_rst_idx", bus.msg_index, 0);
        chk("t6_no_done", done_cnt - d0, 0);

        clear_log(); start_rng(7, 2); wait_done("t6b");
        check_range("t6b", 7, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sender_msg_reader.md
Name: sender_msg_reader

Overview:
- Read-side consumer of the sender tree's message interface.
- After tree expansion completes, drives `msg_index` over a requested range and captures the combinational `{m1,m0}` 128-bit word the tree returns.
- Streams each message out on a valid/ready port with `last` and a done pulse.
- Sits between the sender tree top and the host/DMA egress path; hides the tree's one-cycle BRAM read latency and its lane-mux timing.

Parameters:
- D, 3, tree depth parameter, identical to the tree's D.
- LANES, 16, 64-bit messages per BRAM word; lane = index mod LANES, word = index / LANES.
- NUM_MSG, LANES*2**(D+3), total messages held in the tree's m0/m1 memories.
- FIFO_DEPTH, 2, output skid buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- base_index  in  32  first message index, sampled on accepted start
- count  in  32  number of messages to read, sampled on accepted start
- msg_index  out  32  index presented to the tree; the tree uses index/LANES as BRAM read address and index%LANES as the combinational lane select
- msg_data  in  128  tree output: [127:64]=m1, [63:0]=m0
- m_valid  out  1  output message valid
- m_ready  in  1  downstream accept
- m_data  out  128  captured `{m1,m0}`
- m_last  out  1  high with the final message of the range
- busy  out  1  high from accepted start until the last message is accepted
- done  out  1  one-cycle pulse after the last handshake, or after a count=0 start

Behaviour:
- Reset values: msg_index=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. FSM goes to IDLE, FIFO is emptied, word_tag_valid=0.
- Reset mid-operation discards the range and all buffered messages; no done pulse is issued.
- FSM has three states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on start with count!=0. Latch the index as base_index mod NUM_MSG and latch remaining=count. busy=1.
  - IDLE -> IDLE on start with count=0: done=1 in the next cycle, busy stays 0.
  - start outside IDLE is ignored, with no effect on the range in progress.
- Tree read timing:
  - The BRAM word register holds the word for the address presented in the previous cycle.
  - The lane mux uses the current msg_index.
  - Keep word_tag = the previous cycle's msg_index/LANES and word_tag_valid (1 if the previous cycle was FETCH or DRAIN).
- Capture condition in FETCH: word_tag_valid && word_tag == msg_index/LANES && FIFO not full. When it holds:
  - push msg_data, with a last flag = (remaining==1);
  - advance msg_index to (msg_index+1) mod NUM_MSG;
  - decrement remaining.
- Word crossing costs one bubble cycle. In-word advance costs none, so sustained throughput is LANES messages per LANES+1 cycles.
- The first message costs one cycle after FETCH entry.
- FIFO full: msg_index is held. The word register stays valid because the address is unchanged, so capture resumes in the cycle the FIFO frees an entry.
- Wrap-around: index NUM_MSG-1 advances to 0. This is a word crossing, so one bubble.
- FETCH -> DRAIN after pushing the entry with last flag set. msg_index holds its final value.
- DRAIN -> IDLE when the last-flagged entry handshakes (m_valid && m_ready). done pulses in that same cycle; busy drops in the next cycle.
- Output: m_valid = FIFO not empty; m_data/m_last come from the FIFO head.
  - Push and pop in the same cycle are allowed when full: pop first, so no stall.
  - m_data/m_last are stable while m_valid && !m_ready.
- Arithmetic: all index math is 32-bit unsigned. NUM_MSG is a power of two, so mod is a mask. count > NUM_MSG is legal and rereads wrapped entries.

Decomposition:
- Package `sender_msg_pkg` holds:
  - LANES, MSG_W=64, MSG_PAIR_W=128;
  - a function num_msg(D);
  - the FSM state enum {IDLE, FETCH, DRAIN}.
- Sub-module `msg_skid_fifo`:
  - parameterised width=129 (data+last) and depth;
  - push/pop/full/empty;
  - synchronous reset clears pointers.

Test Plan:
- D=3 (NUM_MSG=1024), base=0, count=20, m_ready=1, msg_data modelled as {index+0x8000, index} via 1-cycle word register plus lane mux:
  - expect m_data=20 messages {i+0x8000,i}, i=0..19;
  - m_last only on i=19; done pulse in the same cycle as that handshake;
  - exactly one bubble at i=16.
- base=1022, count=4: expect indices 1022,1023,0,1 in order; bubble before index 0.
- base=5, count=8, m_ready toggled 1-0-0-1 repeatedly: no loss or duplication; m_data held stable while stalled; msg_index frozen when FIFO full.
- count=0 start: no m_valid; done pulses one cycle later; busy stays 0.
- start asserted again in FETCH with base=100: ignored; the original range completes intact.
- rst asserted mid-range (after 3 messages): next cycle m_valid=0, busy=0, msg_index=0, no done; a new start with base=7, count=2 yields {7,...},{8,...}.
